// File: rtl/corr_pkg.sv
// Shared definitions for the correlation window loader: default sizing,
// window-width helper and FSM state encoding.
package corr_pkg;

    localparam int unsigned SAMPLES_DEFAULT = 2;
    localparam int unsigned OSF_DEFAULT     = 8;

    function automatic int unsigned win_width(input int unsigned samples, input int unsigned osf);
        return samples * osf;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/corr_window_shifter.sv
// W-bit sliding sample window; bit 0 holds the newest sample.
// Exposes the post-shift value so the owner can snapshot it on the accepting edge.
module corr_window_shifter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] window_next
);

    logic [W-1:0] shreg;

    assign window_next = {shreg[W-2:0], din};

    always_ff @(posedge clk) begin
        if (clear) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= window_next;
        end
    end

endmodule

// File: rtl/correlation_window_loader.sv
// Collects an oversampled bit stream into a sliding window and emits window/reference
// snapshots with a one-cycle P strobe, first after a full fill, then every STRIDE samples.
module correlation_window_loader
    import corr_pkg::*;
#(
    parameter int unsigned SAMPLES = SAMPLES_DEFAULT,
    parameter int unsigned OSF     = OSF_DEFAULT,
    parameter int unsigned STRIDE  = 8,
    localparam int unsigned W      = win_width(SAMPLES, OSF)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Enable,
    input  logic         SampleIn,
    input  logic         SampleValid,
    input  logic [W-1:0] RefIn,
    input  logic         RefLoad,
    output logic [W-1:0] DataIn1,
    output logic [W-1:0] DataIn2,
    output logic         P,
    output logic [15:0]  WinCount
);

    localparam int unsigned CW = $clog2(W + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [W-1:0]  ref_q;
    logic [W-1:0]  window_next;
    logic          accept;
    logic          fill_done;
    logic          stride_done;
    logic          emit;
    logic          shift_clear;

    assign accept      = (state != ST_IDLE) && Enable && SampleValid;
    assign cnt_inc     = cnt + CW'(1);
    assign fill_done   = (state == ST_FILL) && (cnt_inc == CW'(W));
    assign stride_done = (state == ST_RUN) && (cnt_inc == CW'(STRIDE));
    assign emit        = accept && (fill_done || stride_done);
    // Window is empty whenever we are idle or being dropped back to idle.
    assign shift_clear = Reset || !Enable || (state == ST_IDLE);

    corr_window_shifter #(
        .W (W)
    ) u_shifter (
        .clk         (Clk),
        .clear       (shift_clear),
        .shift_en    (accept),
        .din         (SampleIn),
        .window_next (window_next)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ref_q    <= '0;
            DataIn1  <= '0;
            DataIn2  <= '0;
            WinCount <= '0;
            P        <= 1'b0;
        end else begin
            P <= emit;

            if (RefLoad) begin
                ref_q <= RefIn;
            end

            if (emit) begin
                DataIn1  <= window_next;
                // A coincident reference load lands in this window.
                DataIn2  <= RefLoad ? RefIn : ref_q;
                WinCount <= WinCount + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (Enable) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (!Enable) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (accept) begin
                        if (fill_done) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                        end else if (stride_done) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_correlation_window_loader.sv
// Scoreboard bench: stimulus pushes expected windows, a negedge monitor checks every P strobe.
// A second instance built with STRIDE=1 covers back-to-back window emission.
module tb_correlation_window_loader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        SampleIn;
    logic        SampleValid;
    logic [15:0] RefIn;
    logic        RefLoad;
    logic [15:0] DataIn1;
    logic [15:0] DataIn2;
    logic        P;
    logic [15:0] WinCount;

    logic        Enable1;
    logic        SampleIn1;
    logic        SampleValid1;
    logic [15:0] RefIn1 = 16'h0;
    logic        RefLoad1 = 1'b0;
    logic [15:0] d1_s1;
    logic [15:0] d2_s1;
    logic        p_s1;
    logic [15:0] cnt_s1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 Clk = ~Clk;

    correlation_window_loader #(
        .SAMPLES (2),
        .OSF     (8),
        .STRIDE  (8)
    ) u_dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .SampleIn    (SampleIn),
        .SampleValid (SampleValid),
        .RefIn       (RefIn),
        .RefLoad     (RefLoad),
        .DataIn1     (DataIn1),
        .DataIn2     (DataIn2),
        .P           (P),
        .WinCount    (WinCount)
    );

    correlation_window_loader #(
        .SAMPLES (2),
        .OSF     (8),
        .STRIDE  (1)
    ) u_dut_s1 (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable1),
        .SampleIn    (SampleIn1),
        .SampleValid (SampleValid1),
        .RefIn       (RefIn1),
        .RefLoad     (RefLoad1),
        .DataIn1     (d1_s1),
        .DataIn2     (d2_s1),
        .P           (p_s1),
        .WinCount    (cnt_s1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (P === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_p: got P=1 expected no window at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("win_data1", 32'(DataIn1), 32'(e.d1));
                check("win_data2", 32'(DataIn2), 32'(e.d2));
                check("win_count", 32'(WinCount), 32'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic ld, input logic [15:0] rv);
        SampleIn    = b;
        SampleValid = 1'b1;
        RefLoad     = ld;
        RefIn       = rv;
        tick();
        SampleValid = 1'b0;
        RefLoad     = 1'b0;
    endtask

    // Sends the low n bits of v, MSB first, with gap idle cycles after each bit.
    task automatic send_bits(input logic [15:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i], 1'b0, 16'h0);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        Reset        = 1'b1;
        Enable       = 1'b0;
        SampleIn     = 1'b0;
        SampleValid  = 1'b0;
        RefIn        = 16'h0;
        RefLoad      = 1'b0;
        Enable1      = 1'b0;
        SampleIn1    = 1'b0;
        SampleValid1 = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;

        check("rst_data1", 32'(DataIn1), 32'h0);
        check("rst_data2", 32'(DataIn2), 32'h0);
        check("rst_count", 32'(WinCount), 32'h0);
        check("rst_p", 32'(P), 32'h0);

        Enable = 1'b1;
        tick();
        RefIn   = 16'h2221;
        RefLoad = 1'b1;
        tick();
        RefLoad = 1'b0;

        // First window: 16'h0003, completing bit issued separately to check latency.
        send_bits(16'h0001, 15, 0);
        check("no_early_p", 32'(P), 32'h0);
        check("no_early_count", 32'(WinCount), 32'h0);
        exp_q.push_back('{d1: 16'h0003, d2: 16'h2221, cnt: 16'd1});
        send_bit(1'b1, 1'b0, 16'h0);
        check("p_latency", 32'(P), 32'h1);
        tick();
        check("p_one_cycle", 32'(P), 32'h0);

        // Stride window with idle gaps: 8'hA5.
        send_bits(16'h0052, 7, 2);
        check("no_p_mid_stride", 32'(P), 32'h0);
        exp_q.push_back('{d1: 16'h03A5, d2: 16'h2221, cnt: 16'd2});
        send_bit(1'b1, 1'b0, 16'h0);
        check("p_latency_gaps", 32'(P), 32'h1);

        // Coincident reference load on the completing edge: 8'h3C.
        send_bits(16'h001E, 7, 0);
        exp_q.push_back('{d1: 16'hA53C, d2: 16'hFFFF, cnt: 16'd3});
        send_bit(1'b0, 1'b1, 16'hFFFF);
        check("p_latency_ref", 32'(P), 32'h1);
        wait_drain("drain_a");

        // Drop Enable mid-fill; a sample offered while disabled is ignored.
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        tick();
        send_bits(16'h03FF, 10, 0);
        Enable      = 1'b0;
        SampleIn    = 1'b1;
        SampleValid = 1'b1;
        tick();
        SampleValid = 1'b0;
        check("hold_data1", 32'(DataIn1), 32'hA53C);
        check("hold_count", 32'(WinCount), 32'd3);
        check("hold_p", 32'(P), 32'h0);
        Enable = 1'b1;
        tick();
        send_bits(16'h091A, 15, 0);
        check("refill_no_p", 32'(P), 32'h0);
        exp_q.push_back('{d1: 16'h1234, d2: 16'hFFFF, cnt: 16'd4});
        send_bit(1'b0, 1'b0, 16'h0);
        check("refill_latency", 32'(P), 32'h1);
        wait_drain("drain_b");

        // Reset on the edge that would complete a stride window.
        send_bits(16'h0000, 7, 0);
        Reset = 1'b1;
        send_bit(1'b1, 1'b0, 16'h0);
        Reset = 1'b0;
        check("rst_mid_p", 32'(P), 32'h0);
        check("rst_mid_data1", 32'(DataIn1), 32'h0);
        check("rst_mid_data2", 32'(DataIn2), 32'h0);
        check("rst_mid_count", 32'(WinCount), 32'h0);
        Enable = 1'b0;
        tick();

        // STRIDE=1 instance: alternating bits starting with 0, continuous valid.
        Enable1 = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            SampleIn1    = 1'((k & 1) != 0);
            SampleValid1 = 1'b1;
            tick();
            if (k == 14) check("s1_no_early_p", 32'(p_s1), 32'h0);
        end
        check("s1_first_p", 32'(p_s1), 32'h1);
        check("s1_first_data", 32'(d1_s1), 32'h5555);
        check("s1_first_ref", 32'(d2_s1), 32'h0);
        check("s1_first_count", 32'(cnt_s1), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            SampleIn1 = 1'(((15 + j) & 1) != 0);
            tick();
            check("s1_p", 32'(p_s1), 32'h1);
            check("s1_data", 32'(d1_s1), ((j & 1) != 0) ? 32'hAAAA : 32'h5555);
            check("s1_count", 32'(cnt_s1), 32'(j + 1));
        end
        SampleValid1 = 1'b0;
        tick();
        check("s1_p_stop", 32'(p_s1), 32'h0);
        check("s1_count_hold", 32'(cnt_s1), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
